// File: rtl/gf180mcu_fd_sc_mcu9t5v0__inv_chain_checker.sv
// rtl/gf180mcu_fd_sc_mcu9t5v0__inv_chain_checker.sv - LFSR-driven self-test checker for inverter cells and chains
module gf180mcu_fd_sc_mcu9t5v0__inv_chain_checker #(
    parameter int          N_VEC  = 256,
    parameter int          LAT    = 2,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int          INVERT = 1,
    parameter int          ERR_W  = 8,
    parameter int          IDX_W  = 8
) (
    input  logic             CLK,
    input  logic             RN,
    inout  wire              VDD,
    inout  wire              VSS,
    input  logic             start,
    input  logic             abort,
    output logic             I_drv,
    input  logic             ZN_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [IDX_W-1:0] first_fail_idx
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [15:0]      SEED_L  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic             EXP_INV = (INVERT != 0);
    localparam int               KW      = $clog2(N_VEC + 1);
    localparam logic [KW-1:0]    K_END   = KW'(N_VEC);
    localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(N_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    // The compare/error registers act as the final resolving stage of the
    // synchroniser, so only LAT-1 plain flops precede the comparison.
    localparam int               SYNC_N  = LAT - 1;

    // Rails are only present for the cell-row netlist; they carry no logic.
    wire unused_rails = VDD ^ VSS;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    state_t                     state_q, state_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [KW-1:0]              drv_k_q, drv_k_d;
    logic                       i_drv_q, i_drv_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       pass_q, pass_d;
    logic [ERR_W-1:0]           err_q, err_d;
    logic [IDX_W-1:0]           ffi_q, ffi_d;
    logic                       ff_seen_q, ff_seen_d;
    logic [SYNC_N-1:0]          zs_q, zs_d;
    logic [LAT-1:0]             pv_q, pv_d;
    logic [LAT-1:0]             pe_q, pe_d;
    logic [LAT-1:0][IDX_W-1:0]  pi_q, pi_d;

    logic             push_v, push_e, clear_pipe, miss, last;
    logic [IDX_W-1:0] push_i;

    // Next-state, stimulus generation, expect pipe and compare logic.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        drv_k_d    = drv_k_q;
        i_drv_d    = i_drv_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        err_d      = err_q;
        ffi_d      = ffi_q;
        ff_seen_d  = ff_seen_q;
        push_v     = 1'b0;
        push_e     = 1'b0;
        push_i     = '0;
        clear_pipe = 1'b0;

        zs_d    = zs_q;
        zs_d[0] = ZN_in;
        for (int i = 1; i < SYNC_N; i++) begin
            zs_d[i] = zs_q[i-1];
        end

        miss = pv_q[LAT-1] && (zs_q[SYNC_N-1] != pe_q[LAT-1]);
        last = pv_q[LAT-1] && (pi_q[LAT-1] == K_LAST);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && !abort) begin
                    // Vector 0 leaves on the accepting edge, straight from the seed.
                    state_d    = ST_RUN;
                    busy_d     = 1'b1;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    ffi_d      = '0;
                    ff_seen_d  = 1'b0;
                    i_drv_d    = SEED_L[0];
                    lfsr_d     = lfsr_next(SEED_L);
                    drv_k_d    = KW'(1);
                    push_v     = 1'b1;
                    push_e     = SEED_L[0] ^ EXP_INV;
                    push_i     = '0;
                    clear_pipe = 1'b1;
                end else if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    busy_d     = 1'b0;
                    pass_d     = 1'b0;
                    clear_pipe = 1'b1;
                end else begin
                    if (drv_k_q < K_END) begin
                        i_drv_d = lfsr_q[0];
                        lfsr_d  = lfsr_next(lfsr_q);
                        drv_k_d = drv_k_q + 1'b1;
                        push_v  = 1'b1;
                        push_e  = lfsr_q[0] ^ EXP_INV;
                        push_i  = IDX_W'(drv_k_q);
                    end
                    if (miss) begin
                        err_d = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
                        if (!ff_seen_q) begin
                            ffi_d     = pi_q[LAT-1];
                            ff_seen_d = 1'b1;
                        end
                    end
                    if (last) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        pv_d = {pv_q[LAT-2:0], push_v};
        pe_d = {pe_q[LAT-2:0], push_e};
        pi_d = {pi_q[LAT-2:0], push_i};
        if (clear_pipe) begin
            pv_d = {{(LAT-1){1'b0}}, push_v};
        end
    end

    // State, stimulus, synchroniser, expect pipe and result registers.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= SEED_L;
            drv_k_q   <= '0;
            i_drv_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffi_q     <= '0;
            ff_seen_q <= 1'b0;
            zs_q      <= '0;
            pv_q      <= '0;
            pe_q      <= '0;
            pi_q      <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            drv_k_q   <= drv_k_d;
            i_drv_q   <= i_drv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffi_q     <= ffi_d;
            ff_seen_q <= ff_seen_d;
            zs_q      <= zs_d;
            pv_q      <= pv_d;
            pe_q      <= pe_d;
            pi_q      <= pi_d;
        end
    end

    assign I_drv          = i_drv_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_q;
    assign first_fail_idx = ffi_q;

endmodule
